// File: rtl/count_sequencer_if.sv
// Control/status bundle between the register block and the count sequencer.
// The master drives commands and settings; the slave (the sequencer) returns status.
interface count_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [WIDTH-1:0] term;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, stop, pause, periodic, term, presc,
    input  count, busy, tick, done, state
  );

  modport slave (
    input  start, stop, pause, periodic, term, presc,
    output count, busy, tick, done, state
  );
endinterface

// File: rtl/count_sequencer.sv
// Bounded, restartable up-counter controller with prescaler, one-shot/periodic
// modes, pause/resume and abort. All status outputs come straight from registers.
module count_sequencer #(
  parameter int WIDTH = 4,
  parameter int PW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  count_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [PW-1:0]    pcnt_reg, pcnt_next;
  logic [WIDTH-1:0] term_s_reg, term_s_next;
  logic [PW-1:0]    presc_s_reg, presc_s_next;
  logic             per_s_reg, per_s_next;
  logic             tick_reg, tick_next;
  logic             done_reg, done_next;
  logic             advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      pcnt_reg    <= '0;
      term_s_reg  <= '0;
      presc_s_reg <= '0;
      per_s_reg   <= 1'b0;
      tick_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      pcnt_reg    <= pcnt_next;
      term_s_reg  <= term_s_next;
      presc_s_reg <= presc_s_next;
      per_s_reg   <= per_s_next;
      tick_reg    <= tick_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pcnt_next    = pcnt_reg;
    term_s_next  = term_s_reg;
    presc_s_next = presc_s_reg;
    per_s_next   = per_s_reg;
    tick_next    = 1'b0;
    done_next    = 1'b0;
    advance      = 1'b0;

    if (bus.stop) begin
      state_next = IDLE;
      count_next = '0;
      pcnt_next  = '0;
    end else if (bus.start) begin
      term_s_next  = bus.term;
      presc_s_next = bus.presc;
      per_s_next   = bus.periodic;
      count_next   = '0;
      pcnt_next    = '0;
      state_next   = RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (bus.pause) state_next = PAUSE;
          else           advance    = 1'b1;
        end
        // Resuming counts in the same cycle, so each paused cycle costs exactly one cycle.
        PAUSE: begin
          if (!bus.pause) begin
            state_next = RUN;
            advance    = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (advance) begin
      if (pcnt_reg == presc_s_reg) begin
        pcnt_next = '0;
        if (count_reg == term_s_reg) begin
          tick_next = 1'b1;
          if (per_s_reg) begin
            count_next = '0;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          count_next = WIDTH'(count_reg + 1'b1);
        end
      end else begin
        pcnt_next = PW'(pcnt_reg + 1'b1);
      end
    end
  end

  assign bus.count = count_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.tick  = tick_reg;
  assign bus.done  = done_reg;
  assign bus.state = state_reg;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed and random stimulus for count_sequencer, checked every cycle against an
// elapsed-time model: count and tick/done are derived from active cycles since start.
module tb_count_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  count_sequencer_if #(.WIDTH(4), .PW(4)) sif ();

  count_sequencer #(.WIDTH(4), .PW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_run, m_paused, m_tick, m_done, m_per;
  int m_elapsed, m_count, m_n, m_p;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("count", int'(sif.count), m_count);
    chk("state", int'(sif.state), !m_run ? 0 : (m_paused ? 2 : 1));
    chk("busy",  int'(sif.busy),  int'(m_run));
    chk("tick",  int'(sif.tick),  int'(m_tick));
    chk("done",  int'(sif.done),  int'(m_done));
  endtask

  task automatic model_reset();
    m_run = 0; m_paused = 0; m_tick = 0; m_done = 0; m_per = 0;
    m_elapsed = 0; m_count = 0; m_n = 0; m_p = 0;
  endtask

  // One edge of the model: count is elapsed active cycles divided by step period.
  task automatic model_edge();
    int period;
    m_tick = 0;
    m_done = 0;
    if (sif.stop) begin
      m_run = 0; m_paused = 0; m_count = 0;
    end else if (sif.start) begin
      m_n = int'(sif.term); m_p = int'(sif.presc); m_per = sif.periodic;
      m_elapsed = 0; m_run = 1; m_paused = 0; m_count = 0;
    end else if (m_run) begin
      if (sif.pause) begin
        m_paused = 1;
      end else begin
        m_paused = 0;
        m_elapsed++;
        period = (m_n + 1) * (m_p + 1);
        if (m_per) begin
          m_count = (m_elapsed / (m_p + 1)) % (m_n + 1);
          m_tick  = (m_elapsed % period) == 0;
        end else if (m_elapsed == period) begin
          m_tick = 1; m_done = 1; m_run = 0; m_count = m_n;
        end else begin
          m_count = m_elapsed / (m_p + 1);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_all();
  endtask

  task automatic set_cmd(input bit st, input bit sp, input bit pa, input bit per,
                         input int t, input int p);
    sif.start = st; sif.stop = sp; sif.pause = pa; sif.periodic = per;
    sif.term = 4'(t); sif.presc = 4'(p);
  endtask

  task automatic start_run(input int t, input int p, input bit per);
    set_cmd(1, 0, 0, per, t, p);
    step();
    sif.start = 0;
  endtask

  task automatic run_until_done(input int bound, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!sif.done && cyc < bound);
  endtask

  initial begin
    int cyc, ticks, maxc;
    model_reset();
    set_cmd(0, 0, 0, 0, 0, 0);

    // Reset values
    #12;
    chk_all();
    @(negedge clk);
    reset = 1'b1;
    step();
    step();

    // One-shot term=3 presc=1: steps at +2,+4,+6, done at +8
    start_run(3, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k % 2 == 0) chk("oneshot_count", int'(sif.count), k / 2);
    end
    run_until_done(10, cyc);
    chk("oneshot_done_cycle", cyc + 6, 8);
    step();
    step();
    chk("oneshot_hold", int'(sif.count), 3);

    // Periodic term=2 presc=0: tick every 3 cycles, then stop
    start_run(2, 0, 1);
    ticks = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      ticks += int'(sif.tick);
    end
    chk("periodic_ticks", ticks, 3);
    sif.stop = 1;
    step();
    sif.stop = 0;
    chk("stop_count", int'(sif.count), 0);
    chk("stop_state", int'(sif.state), 0);

    // Pause 5 cycles once count=1: done at +20 instead of +15
    start_run(4, 2, 0);
    cyc = 0;
    do begin step(); cyc++; end while (sif.count != 1 && cyc < 20);
    sif.pause = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      cyc++;
    end
    chk("pause_state", int'(sif.state), 2);
    chk("pause_count", int'(sif.count), 1);
    sif.pause = 0;
    ticks = cyc;
    run_until_done(30, cyc);
    chk("pause_done_cycle", ticks + cyc, 20);

    // Stop and start together: stop wins
    start_run(5, 0, 1);
    step();
    step();
    sif.stop = 1; sif.start = 1;
    step();
    set_cmd(0, 0, 0, 0, 0, 0);
    chk("stopstart_state", int'(sif.state), 0);

    // Restart coinciding with terminal step, then mid-run term change ignored
    start_run(3, 0, 1);
    step(); step(); step();
    set_cmd(1, 0, 0, 0, 7, 0);
    step();
    chk("restart_no_tick", int'(sif.tick), 0);
    chk("restart_count", int'(sif.count), 0);
    set_cmd(0, 0, 0, 1, 2, 3);
    cyc = 0;
    do begin step(); cyc++; end while (sif.count != 7 && cyc < 20);
    chk("term_change_ignored", int'(sif.count), 7);
    step();
    chk("new_run_done", int'(sif.done), 1);

    // Boundaries
    start_run(0, 0, 0);
    run_until_done(5, cyc);
    chk("term0_done_cycle", cyc, 1);
    start_run(15, 15, 0);
    maxc = 0;
    cyc = 0;
    do begin
      step();
      cyc++;
      if (int'(sif.count) > maxc) maxc = int'(sif.count);
    end while (!sif.done && cyc < 300);
    chk("term15_done_cycle", cyc, 256);
    chk("term15_max", maxc, 15);

    // Asynchronous reset mid-run at count=5
    start_run(9, 0, 0);
    cyc = 0;
    do begin step(); cyc++; end while (sif.count != 5 && cyc < 20);
    reset = 1'b0;
    #2;
    model_reset();
    chk_all();
    @(negedge clk);
    reset = 1'b1;
    start_run(1, 0, 0);
    run_until_done(5, cyc);
    chk("after_reset_done_cycle", cyc, 2);

    // Random stimulus
    for (int k = 0; k < 400; k++) begin
      set_cmd($urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 4) == 0, 1'($urandom), $urandom_range(0, 15),
              $urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
